// File: rtl/nco_fsk_scheduler_if.sv
// Symbol stream and tone-table configuration bus for the FSK scheduler.
// The master side is the symbol/config source; the slave side is the scheduler.
interface nco_fsk_scheduler_if #(
  parameter int SYMBOL_BITS = 2,
  parameter int INC_WIDTH   = 8,
  parameter int DWELL_WIDTH = 16
);

  // Tone-table write port
  logic                   cfg_we;
  logic [SYMBOL_BITS-1:0] cfg_addr;
  logic [INC_WIDTH-1:0]   cfg_data;

  // Per-symbol dwell, sampled when a symbol is accepted
  logic [DWELL_WIDTH-1:0] dwell;

  // Symbol handshake
  logic                   sym_valid;
  logic [SYMBOL_BITS-1:0] sym_data;
  logic                   sym_ready;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_data,
    output dwell,
    output sym_valid,
    output sym_data,
    input  sym_ready
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_data,
    input  dwell,
    input  sym_valid,
    input  sym_data,
    output sym_ready
  );

endinterface

// File: rtl/nco_fsk_scheduler.sv
// FSK tone scheduler: maps accepted symbols to phase increments from a
// programmable tone table and holds each increment for a programmable dwell.
// Drives increment 0 (NCO phase frozen) whenever no symbol is active.
module nco_fsk_scheduler #(
  parameter int SYMBOL_BITS = 2,
  parameter int INC_WIDTH   = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  nco_fsk_scheduler_if.slave   bus,
  output logic [INC_WIDTH-1:0] phase_increment,
  output logic                 busy,
  output logic                 underrun
);

  localparam int TABLE_DEPTH = 2 ** SYMBOL_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [DWELL_WIDTH-1:0] cnt_reg, cnt_next;
  logic [INC_WIDTH-1:0]   inc_reg, inc_next;
  logic                   underrun_reg, underrun_next;

  // Tone table is register based: every entry must clear on reset.
  logic [INC_WIDTH-1:0]   tone_reg [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] entry_we;

  logic                   ready_int;
  logic                   accept;
  logic [INC_WIDTH-1:0]   tone_sel;
  logic [DWELL_WIDTH-1:0] cnt_load;

  // One write-enable per table entry, decoded from the config address.
  genvar gi;
  generate
    for (gi = 0; gi < TABLE_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = bus.cfg_we && (bus.cfg_addr == SYMBOL_BITS'(gi));
    end
  endgenerate

  // Tone-table storage; the scheduler reads the pre-write value in the same
  // cycle, so a colliding accept sees the old entry.
  always_ff @(posedge clock) begin
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (reset) begin
        tone_reg[i] <= '0;
      end else if (entry_we[i]) begin
        tone_reg[i] <= bus.cfg_data;
      end
    end
  end

  // Ready is a function of state and counter only, forced low during reset.
  assign ready_int     = (state_reg == IDLE) || (cnt_reg == '0);
  assign bus.sym_ready = ready_int && !reset;
  assign accept        = bus.sym_valid && bus.sym_ready;

  // Tone lookup and counter reload value: a dwell of 0 behaves as 1 cycle,
  // and the counter holds (dwell - 1) so the last tone cycle is cnt == 0.
  assign tone_sel = tone_reg[bus.sym_data];
  assign cnt_load = (bus.dwell == '0) ? '0 : (bus.dwell - 1'b1);

  // Next-state, counter and output-register logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    inc_next      = inc_reg;
    underrun_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        inc_next = '0;
        if (accept) begin
          inc_next   = tone_sel;
          cnt_next   = cnt_load;
          state_next = TONE;
        end
      end

      TONE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (accept) begin
          // Back-to-back symbol: reload without a gap cycle.
          inc_next = tone_sel;
          cnt_next = cnt_load;
        end else begin
          inc_next      = '0;
          underrun_next = 1'b1;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        inc_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any symbol in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      inc_reg      <= '0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      inc_reg      <= inc_next;
      underrun_reg <= underrun_next;
    end
  end

  assign phase_increment = inc_reg;
  assign busy            = (state_reg == TONE);
  assign underrun        = underrun_reg;

endmodule

// File: tb/tb_nco_fsk_scheduler.sv
// Self-checking bench for nco_fsk_scheduler: directed scenarios followed by
// randomized traffic, compared every cycle against a symbol-schedule model.
module tb_nco_fsk_scheduler;

  localparam int SB = 2;
  localparam int IW = 8;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic [IW-1:0] phase_increment;
  logic          busy;
  logic          underrun;

  nco_fsk_scheduler_if #(.SYMBOL_BITS(SB), .INC_WIDTH(IW), .DWELL_WIDTH(DW)) bus ();

  nco_fsk_scheduler #(.SYMBOL_BITS(SB), .INC_WIDTH(IW), .DWELL_WIDTH(DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .phase_increment (phase_increment),
    .busy            (busy),
    .underrun        (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the tone table contents, the increment on the output,
  // and how many output cycles of the current symbol remain (including the
  // one now showing); 0 means nothing is being emitted.
  int n_cmp = 0;
  int n_bad = 0;
  int m_tbl [4];
  int m_inc = 0;
  int m_left = 0;
  int m_und = 0;
  bit last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance the
  // model across the edge, then check the registered outputs.
  task automatic cyc(input bit rst, input bit v, input int s, input int dw,
                     input bit we, input int a, input int d);
    bit exp_ready;
    bit acc;
    int dd;
    reset         = rst;
    bus.sym_valid = v;
    bus.sym_data  = SB'(s);
    bus.dwell     = DW'(dw);
    bus.cfg_we    = we;
    bus.cfg_addr  = SB'(a);
    bus.cfg_data  = IW'(d);
    #1;
    exp_ready = !rst && (m_left <= 1);
    chk("sym_ready", {31'd0, bus.sym_ready}, {31'd0, exp_ready});
    acc = v && exp_ready;
    @(posedge clock);
    if (rst) begin
      m_left = 0;
      m_inc  = 0;
      m_und  = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
      acc = 0;
    end else begin
      m_und = 0;
      if (acc) begin
        dd     = (dw == 0) ? 1 : dw;
        m_inc  = m_tbl[s];
        m_left = dd;
        $display("t=%0t accept sym=%0d inc=%0d cycles=%0d", $time, s, m_inc, dd);
      end else if (m_left == 1) begin
        m_inc  = 0;
        m_left = 0;
        m_und  = 1;
      end else if (m_left > 1) begin
        m_left--;
      end
      if (we) m_tbl[a] = d;
    end
    last_acc = acc;
    #1;
    chk("phase_increment", {24'd0, phase_increment}, 32'(m_inc));
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("underrun", {31'd0, underrun}, 32'(m_und));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    int guard;
    foreach (m_tbl[i]) m_tbl[i] = 0;

    // Reset, then idle for 20 cycles
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 1, 1, 55);
    idle(20);

    // Single symbol: table[1]=10, dwell 5
    cyc(0, 0, 0, 0, 1, 1, 10);
    cyc(0, 1, 1, 5, 0, 0, 0);
    idle(8);

    // Back-to-back: table={4,8,16,32}, dwell 3, valid held high
    cyc(0, 0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 0, 1, 1, 8);
    cyc(0, 0, 0, 0, 1, 2, 16);
    cyc(0, 0, 0, 0, 1, 3, 32);
    k = 0;
    guard = 0;
    while (k < 4 && guard < 40) begin
      cyc(0, 1, k, 3, 0, 0, 0);
      if (last_acc) k++;
      guard++;
    end
    chk("b2b_all_accepted", 32'(k), 32'd4);
    idle(5);

    // dwell = 0 behaves as a single cycle
    cyc(0, 1, 2, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 0, 0);
    idle(3);

    // Table write colliding with accept of the same address
    cyc(0, 0, 0, 0, 1, 1, 10);
    idle(1);
    cyc(0, 1, 1, 2, 1, 1, 20);
    idle(3);
    cyc(0, 1, 1, 2, 0, 0, 0);
    idle(3);

    // Reset in the middle of a long symbol
    cyc(0, 1, 1, 100, 0, 0, 0);
    idle(39);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 3, 0, 0, 0);
    idle(5);
    cyc(0, 0, 0, 0, 1, 2, 77);
    cyc(0, 1, 2, 2, 0, 0, 0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 4)),
          ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 255)));
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nco_fsk_scheduler.md
Name: nco_fsk_scheduler

Overview:
Sequences the phase-increment input of the NCO to generate multi-tone FSK. Accepts a stream of symbols over a valid/ready handshake, maps each symbol to a programmable tone increment, and holds that increment for a programmable dwell of clock cycles. It sits directly in front of the NCO's phase_increment input. It drives an increment of 0, which freezes the NCO phase, whenever no symbol is active.

Parameters:
SYMBOL_BITS, 2, symbol width; tone table holds 2**SYMBOL_BITS entries
INC_WIDTH, 8, phase-increment width; must match the NCO's phase_increment
DWELL_WIDTH, 16, width of the per-symbol dwell count

Ports:
clock  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cfg_we  input  1  tone-table write strobe
cfg_addr  input  SYMBOL_BITS  tone-table write address
cfg_data  input  INC_WIDTH  tone-table write data (phase increment)
dwell  input  DWELL_WIDTH  cycles per symbol; sampled when a symbol is accepted
sym_valid  input  1  symbol available
sym_data  input  SYMBOL_BITS  symbol value
sym_ready  output  1  scheduler can accept a symbol this cycle
phase_increment  output  INC_WIDTH  to NCO; registered
busy  output  1  a symbol is currently being emitted
underrun  output  1  one-cycle pulse: a symbol ended and no next symbol was present

Behaviour:
- Reset (sync, active-high) values:
  - phase_increment=0, busy=0, underrun=0.
  - All tone-table entries=0, dwell counter=0, state=IDLE.
  - sym_ready=0 while reset is high.
  - Reset asserted mid-symbol aborts the symbol. Outputs take reset values on the next edge.
- Acceptance: a symbol is accepted on a posedge where sym_valid && sym_ready.
- sym_ready is combinational from state and counter only. It never depends on sym_valid.
- The dwell used for a symbol is D = max(dwell,1); dwell=0 is treated as 1.
- States:
  - IDLE:
    - sym_ready=1, busy=0, phase_increment=0.
    - On accept: phase_increment<=table[sym_data], cnt<=D-1, go to TONE.
  - TONE:
    - busy=1. sym_ready=1 only when cnt==0, i.e. the last cycle of the current symbol.
    - cnt!=0: cnt<=cnt-1, phase_increment held.
    - cnt==0 with accept: load the next symbol exactly as in IDLE and stay in TONE. This gives back-to-back symbols with zero gap cycles.
    - cnt==0 without accept: phase_increment<=0, underrun<=1 for one cycle, go to IDLE.
- Timing:
  - phase_increment changes on the edge that accepts a symbol.
  - Each symbol's increment is present on phase_increment for exactly D consecutive cycles.
- Tone table:
  - Written on posedge when cfg_we=1; writes are allowed in any state.
  - A symbol accepted in the same cycle as a write to its own address uses the old entry (read-before-write).
  - The new entry applies to symbols accepted on later edges.
  - A symbol already in progress is never retuned by a table write.
- dwell changes affect only symbols accepted after the change.
- Arithmetic: the counter is DWELL_WIDTH bits, counts down only, and never wraps (it reloads at 0). No overflow is possible.
- underrun is informational only. It does not pulse when leaving reset or on the IDLE->TONE transition.

Test Plan:
- Reset then idle: hold sym_valid=0 for 20 cycles -> phase_increment=0, busy=0, sym_ready=1, underrun never 1.
- Single symbol: table[1]=8'd10, dwell=5, send symbol 1 -> phase_increment=10 for exactly 5 cycles, then 0. underrun pulses once on the cycle phase_increment returns to 0. sym_ready is 1 only in the 5th cycle of the tone and again once back in IDLE.
- Back-to-back: table={4,8,16,32}, dwell=3, sym_valid held high with symbols 0,1,2,3 -> increments 4,4,4,8,8,8,16,16,16,32,32,32 with no gaps, then 0 and one underrun pulse.
- dwell=0: send symbols 2,3 with table[2]=16, table[3]=32 -> each lasts 1 cycle, sym_ready stays 1 throughout, sequence 16,32,0.
- Table write collision: table[1]=10, then write cfg_data=20 to address 1 in the same cycle symbol 1 is accepted -> that symbol emits 10. The next symbol 1 emits 20.
- Reset mid-symbol: dwell=100, assert reset at cycle 40 of the tone -> next cycle phase_increment=0, busy=0, table cleared. A subsequent symbol emits increment 0 until the table is rewritten.
